pll_cfg_seq: RTL and testbench

- Sequences runtime reconfiguration of the main system PLL (50 MHz ref, 4 outputs) through its Avalon-MM reconfig port.
- Switches between two frequency presets, e.g. NTSC 21.477 MHz family vs PAL family.
- Holds a core reset until the PLL is locked and stable.
- Sits between the OSD/video-mode logic and the PLL reconfig IP, in the refclk domain.

---
 rtl/pll_cfg_seq_if.sv | 28 ++
 rtl/pll_cfg_seq.sv | 208 ++++++++++++++++++++
 tb/tb_pll_cfg_seq.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_seq_if.sv
// Avalon-MM management bus between the PLL config sequencer and the PLL
// reconfiguration IP. The sequencer is the master.
interface pll_cfg_seq_if;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_read;
    logic        mgmt_waitrequest;
    logic [31:0] mgmt_readdata;

    modport master (
        output mgmt_address,
        output mgmt_writedata,
        output mgmt_write,
        output mgmt_read,
        input  mgmt_waitrequest,
        input  mgmt_readdata
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_writedata,
        input  mgmt_write,
        input  mgmt_read,
        output mgmt_waitrequest,
        output mgmt_readdata
    );
endinterface

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer. Writes one of two frequency presets into the
// PLL reconfig IP, kicks off the update, then holds core_rst until the PLL has
// been locked for LOCK_STABLE consecutive cycles.
// Optional: define PLL_CFG_READBACK_EN to read back and verify every register
// write (except the start write) before moving on.
module pll_cfg_seq #(
    parameter logic [31:0] P0_N  = 32'h0000_0000,
    parameter logic [31:0] P0_M  = 32'h0000_0000,
    parameter logic [31:0] P0_K  = 32'h0000_0000,
    parameter logic [17:0] P0_C0 = 18'h0,
    parameter logic [17:0] P0_C1 = 18'h0,
    parameter logic [17:0] P0_C2 = 18'h0,
    parameter logic [17:0] P0_C3 = 18'h0,
    parameter logic [31:0] P1_N  = 32'h0000_0000,
    parameter logic [31:0] P1_M  = 32'h0000_0000,
    parameter logic [31:0] P1_K  = 32'h0000_0000,
    parameter logic [17:0] P1_C0 = 18'h0,
    parameter logic [17:0] P1_C1 = 18'h0,
    parameter logic [17:0] P1_C2 = 18'h0,
    parameter logic [17:0] P1_C3 = 18'h0,
    parameter int          LOCK_STABLE  = 1024,
    parameter int          LOCK_TIMEOUT = 2097152
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_req,
    input  logic          cfg_sel,
    input  logic          pll_locked,
    pll_cfg_seq_if.master mgmt,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cur_sel
);

    localparam int SW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    IDX_START    = 4'd8;

`ifdef PLL_CFG_READBACK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READBACK, ST_LOCK_WAIT, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_LOCK_WAIT, ST_DONE} state_t;
`endif

    state_t          state, next_state;
    logic [3:0]      idx;
    logic            act;        // current Avalon strobe phase is active
    logic            sel_q;
    logic            pend, pend_sel;
    logic [SW-1:0]   stable_cnt;
    logic [TW-1:0]   to_cnt;
    logic            to_en;      // timeout only armed after a start-write
    logic            start, xfer_ok, stable_hit, tmo_hit, in_xfer;
    logic [31:0]     wr_word;

    // Register address for each step of the write list.
    function automatic logic [5:0] wr_addr(input logic [3:0] i);
        case (i)
            4'd0:                   wr_addr = 6'd0;
            4'd1:                   wr_addr = 6'd3;
            4'd2:                   wr_addr = 6'd4;
            4'd3:                   wr_addr = 6'd7;
            4'd4, 4'd5, 4'd6, 4'd7: wr_addr = 6'd5;
            default:                wr_addr = 6'd2;
        endcase
    endfunction

    // Data word for each step; C-counter writes carry the counter index.
    function automatic logic [31:0] wr_data(input logic [3:0] i, input logic s);
        logic [17:0] c;
        case (i[1:0])
            2'd0:    c = s ? P1_C0 : P0_C0;
            2'd1:    c = s ? P1_C1 : P0_C1;
            2'd2:    c = s ? P1_C2 : P0_C2;
            default: c = s ? P1_C3 : P0_C3;
        endcase
        case (i)
            4'd1:                   wr_data = s ? P1_N : P0_N;
            4'd2:                   wr_data = s ? P1_M : P0_M;
            4'd3:                   wr_data = s ? P1_K : P0_K;
            4'd4, 4'd5, 4'd6, 4'd7: wr_data = {9'b0, 3'b0, i[1:0], c};
            default:                wr_data = 32'h0;
        endcase
    endfunction

`ifdef PLL_CFG_READBACK_EN
    logic rd_ok, rb_bad;
`else
    logic unused_rd;
    assign unused_rd = ^mgmt.mgmt_readdata;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOCK_WAIT;
        else     state <= next_state;
    end

    // Next-state decode and all bus/status outputs.
    always_comb begin
        next_state = state;
        start      = cfg_req || pend;
        wr_word    = wr_data(idx, sel_q);
        xfer_ok    = (state == ST_WRITE) && act && !mgmt.mgmt_waitrequest;
        stable_hit = (state == ST_LOCK_WAIT) && pll_locked && (stable_cnt == STABLE_LAST);
        tmo_hit    = (state == ST_LOCK_WAIT) && to_en && (to_cnt == TIMEOUT_LAST) && !stable_hit;
        in_xfer    = (state == ST_WRITE);
        mgmt.mgmt_read = 1'b0;
`ifdef PLL_CFG_READBACK_EN
        rd_ok   = (state == ST_READBACK) && act && !mgmt.mgmt_waitrequest;
        rb_bad  = idx[2] ? (mgmt.mgmt_readdata[17:0] != wr_word[17:0])
                         : (mgmt.mgmt_readdata != wr_word);
        in_xfer = in_xfer || (state == ST_READBACK);
        mgmt.mgmt_read = (state == ST_READBACK) && act;
`endif
        mgmt.mgmt_address   = in_xfer ? wr_addr(idx) : 6'd0;
        mgmt.mgmt_writedata = in_xfer ? wr_word : 32'h0;
        mgmt.mgmt_write     = (state == ST_WRITE) && act;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        core_rst = !((state == ST_DONE) || ((state == ST_IDLE) && !err));

        case (state)
            ST_IDLE:      if (start) next_state = ST_WRITE;
`ifdef PLL_CFG_READBACK_EN
            ST_WRITE:     if (xfer_ok) next_state = (idx == IDX_START) ? ST_LOCK_WAIT : ST_READBACK;
            ST_READBACK:  if (rd_ok) next_state = rb_bad ? ST_IDLE : ST_WRITE;
`else
            ST_WRITE:     if (xfer_ok && (idx == IDX_START)) next_state = ST_LOCK_WAIT;
`endif
            ST_LOCK_WAIT: begin
                if (stable_hit)   next_state = ST_DONE;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_DONE:      next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Sequencing registers: write index, strobe phase, lock counters, status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 4'd0;
            act        <= 1'b0;
            sel_q      <= 1'b0;
            pend       <= 1'b0;
            pend_sel   <= 1'b0;
            stable_cnt <= '0;
            to_cnt     <= '0;
            to_en      <= 1'b0;
            err        <= 1'b0;
            cur_sel    <= 1'b0;
        end else begin
            if (cfg_req && (state != ST_IDLE)) begin
                pend     <= 1'b1;
                pend_sel <= cfg_sel;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel_q <= cfg_req ? cfg_sel : pend_sel;
                        pend  <= 1'b0;
                        err   <= 1'b0;
                        idx   <= 4'd0;
                        act   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (xfer_ok) begin
                        if (idx == IDX_START) begin
                            stable_cnt <= '0;
                            to_cnt     <= '0;
                            to_en      <= 1'b1;
                        end else begin
`ifndef PLL_CFG_READBACK_EN
                            act <= 1'b0;
                            idx <= idx + 4'd1;
`endif
                        end
                    end else if (!act) begin
                        act <= 1'b1;
                    end
                end
`ifdef PLL_CFG_READBACK_EN
                ST_READBACK: begin
                    if (rd_ok) begin
                        if (rb_bad) err <= 1'b1;
                        else        idx <= idx + 4'd1;
                    end
                end
`endif
                ST_LOCK_WAIT: begin
                    if (!pll_locked)                stable_cnt <= '0;
                    else if (stable_cnt != STABLE_LAST) stable_cnt <= stable_cnt + SW'(1);
                    if (to_en && (to_cnt != TIMEOUT_LAST)) to_cnt <= to_cnt + TW'(1);
                    if (tmo_hit)    err     <= 1'b1;
                    if (stable_hit) cur_sel <= sel_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed bench for pll_cfg_seq: Avalon slave model with programmable stall,
// write log, and table of expected write words for both presets.
`timescale 1ns/1ps
module tb_pll_cfg_seq;

    localparam int LS = 16;
    localparam int LT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_req = 1'b0;
    logic cfg_sel = 1'b0;
    logic pll_locked = 1'b1;
    logic core_rst, busy, done, err, cur_sel;

    pll_cfg_seq_if bus();

    always #5 clk = ~clk;

    pll_cfg_seq #(
        .P0_N(32'h0000_0101), .P0_M(32'h0000_0505), .P0_K(32'h0000_0707),
        .P0_C0(18'h0_0011), .P0_C1(18'h0_0022), .P0_C2(18'h0_0033), .P0_C3(18'h3_0044),
        .P1_N(32'h0000_0202), .P1_M(32'h0000_0A0A), .P1_K(32'h8000_1234),
        .P1_C0(18'h1_0101), .P1_C1(18'h0_0202), .P1_C2(18'h2_0303), .P1_C3(18'h3_FFFF),
        .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .pll_locked(pll_locked), .mgmt(bus),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err), .cur_sel(cur_sel)
    );

    // Slave model and monitor state
    int          log_n = 0;
    logic [5:0]  log_addr [0:127];
    logic [31:0] log_data [0:127];
    logic [31:0] rb_mem   [0:63];
    int          stall_at = -1;
    int          stall_until = 0;
    int          stall_used = 0;
    int          wr_cyc7 = 0, hold_viol = 0, gap_viol = 0, rd_seen = 0;
    logic        prev_stall = 1'b0, prev_xfer = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        corrupt = 1'b0;

    assign bus.mgmt_waitrequest = bus.mgmt_write && (log_n == stall_at) && (stall_used < stall_until);
    assign bus.mgmt_readdata = rb_mem[bus.mgmt_address] ^
                               ((corrupt && bus.mgmt_address == 6'd3) ? 32'h1 : 32'h0);

    always @(posedge clk) begin
        if (bus.mgmt_write) begin
            if (bus.mgmt_address == 6'd7) wr_cyc7 <= wr_cyc7 + 1;
            if (prev_stall && (bus.mgmt_address != prev_addr || bus.mgmt_writedata != prev_data))
                hold_viol <= hold_viol + 1;
            if (prev_xfer) gap_viol <= gap_viol + 1;
            if (bus.mgmt_waitrequest) begin
                stall_used <= stall_used + 1;
            end else if (log_n < 128) begin
                log_addr[log_n] <= bus.mgmt_address;
                log_data[log_n] <= bus.mgmt_writedata;
                rb_mem[bus.mgmt_address] <= bus.mgmt_writedata;
                log_n <= log_n + 1;
            end
        end
        if (bus.mgmt_read) rd_seen <= rd_seen + 1;
        prev_stall <= bus.mgmt_write && bus.mgmt_waitrequest;
        prev_xfer  <= bus.mgmt_write && !bus.mgmt_waitrequest;
        prev_addr  <= bus.mgmt_address;
        prev_data  <= bus.mgmt_writedata;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        int          idx;
        logic [5:0]  addr;
        logic [31:0] data;
    } wvec_t;
    wvec_t vec [0:17];

    task automatic cmp_seq(input logic s, input int base);
        for (int i = 0; i < 18; i++) begin
            if (vec[i].sel == s) begin
                check($sformatf("wr%0d_sel%0d_addr", vec[i].idx, s),
                      32'(log_addr[base + vec[i].idx]), 32'(vec[i].addr));
                check($sformatf("wr%0d_sel%0d_data", vec[i].idx, s),
                      log_data[base + vec[i].idx], vec[i].data);
            end
        end
    endtask

    task automatic pulse_req(input logic s);
        @(negedge clk);
        cfg_req = 1'b1;
        cfg_sel = s;
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_b({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_log(input string name, input int target);
        int n;
        n = 0;
        while (log_n < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_log_reached"}, log_n, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, w7;

        vec[0]  = '{1'b1, 0, 6'd0, 32'h0000_0000};
        vec[1]  = '{1'b1, 1, 6'd3, 32'h0000_0202};
        vec[2]  = '{1'b1, 2, 6'd4, 32'h0000_0A0A};
        vec[3]  = '{1'b1, 3, 6'd7, 32'h8000_1234};
        vec[4]  = '{1'b1, 4, 6'd5, 32'h0001_0101};
        vec[5]  = '{1'b1, 5, 6'd5, 32'h0004_0202};
        vec[6]  = '{1'b1, 6, 6'd5, 32'h000A_0303};
        vec[7]  = '{1'b1, 7, 6'd5, 32'h000F_FFFF};
        vec[8]  = '{1'b1, 8, 6'd2, 32'h0000_0000};
        vec[9]  = '{1'b0, 0, 6'd0, 32'h0000_0000};
        vec[10] = '{1'b0, 1, 6'd3, 32'h0000_0101};
        vec[11] = '{1'b0, 2, 6'd4, 32'h0000_0505};
        vec[12] = '{1'b0, 3, 6'd7, 32'h0000_0707};
        vec[13] = '{1'b0, 4, 6'd5, 32'h0000_0011};
        vec[14] = '{1'b0, 5, 6'd5, 32'h0004_0022};
        vec[15] = '{1'b0, 6, 6'd5, 32'h0008_0033};
        vec[16] = '{1'b0, 7, 6'd5, 32'h000F_0044};
        vec[17] = '{1'b0, 8, 6'd2, 32'h0000_0000};

        // Reset values, then lock-stable release with pll_locked constant
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(bus.mgmt_address), 32'h0);
        check("rst_wdata", bus.mgmt_writedata, 32'h0);
        check_b("rst_write", bus.mgmt_write, 1'b0);
        check_b("rst_read", bus.mgmt_read, 1'b0);
        check_b("rst_core_rst", core_rst, 1'b1);
        check_b("rst_busy", busy, 1'b1);
        check_b("rst_done", done, 1'b0);
        check_b("rst_err", err, 1'b0);
        check_b("rst_cur_sel", cur_sel, 1'b0);
        rst = 1'b0;
        n = 0;
        while (core_rst && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("release_cycles", n, LS);
        check_b("release_done", done, 1'b1);
        @(posedge clk); #1;
        check_b("release_busy", busy, 1'b0);
        check_b("release_done_end", done, 1'b0);
        check_b("release_core_rst", core_rst, 1'b0);
        check("release_no_bus", log_n, 0);

        // Preset 1, no waitrequest
        base = log_n;
        pulse_req(1'b1);
        wait_done("seq1");
        check_b("seq1_cur_sel", cur_sel, 1'b1);
        check("seq1_count", log_n - base, 9);
        cmp_seq(1'b1, base);
        check("seq1_idx5_cnt_field", 32'(log_data[base + 5][22:18]), 32'd1);
        @(negedge clk);
        check_b("seq1_done_pulse", done, 1'b0);
        check_b("seq1_busy_idle", busy, 1'b0);
        check_b("seq1_core_rst", core_rst, 1'b0);

        // Preset 0, five waitrequest cycles on idx3
        base = log_n;
        stall_at = base + 3;
        stall_until = stall_used + 5;
        w7 = wr_cyc7;
        pulse_req(1'b0);
        wait_done("stall");
        check("stall_addr7_cycles", wr_cyc7 - w7, 6);
        check("stall_hold_viol", hold_viol, 0);
        check("stall_count", log_n - base, 9);
        cmp_seq(1'b0, base);
        check_b("stall_cur_sel", cur_sel, 1'b0);

        // Lock drops at stable count 10, restart from the final rising edge
        base = log_n;
        pulse_req(1'b1);
        wait_log("glitch", base + 9);
        repeat (10) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("glitch_cycles", n, LS);
        check_b("glitch_cur_sel", cur_sel, 1'b1);

        // Timeout with lock never arriving
        pll_locked = 1'b0;
        base = log_n;
        pulse_req(1'b0);
        wait_log("tmo", base + 9);
        n = 0;
        while (!err && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycles", n, LT);
        check_b("tmo_core_rst", core_rst, 1'b1);
        check_b("tmo_busy", busy, 1'b0);
        check_b("tmo_cur_sel_kept", cur_sel, 1'b1);
        repeat (3) @(negedge clk);
        check_b("tmo_core_rst_held", core_rst, 1'b1);
        check_b("tmo_err_sticky", err, 1'b1);
        pll_locked = 1'b1;
        pulse_req(1'b1);
        check_b("tmo_err_cleared", err, 1'b0);
        check_b("tmo_retry_busy", busy, 1'b1);
        wait_done("tmo_retry");
        @(negedge clk);
        check_b("tmo_retry_core_rst", core_rst, 1'b0);

        // Pending request during WRITE, last cfg_sel wins
        base = log_n;
        pulse_req(1'b1);
        repeat (2) @(negedge clk);
        pulse_req(1'b1);
        pulse_req(1'b0);
        wait_done("pend1");
        check_b("pend1_cur_sel", cur_sel, 1'b1);
        @(negedge clk);
        wait_done("pend2");
        check_b("pend2_cur_sel", cur_sel, 1'b0);
        check("pend_count", log_n - base, 18);
        cmp_seq(1'b0, base + 9);
        repeat (40) @(negedge clk);
        check_b("pend_idle", busy, 1'b0);
        check("pend_no_third", log_n - base, 18);

        // Reset in the middle of a stalled transfer with a request pending
        base = log_n;
        stall_at = base + 2;
        stall_until = stall_used + 1000;
        pulse_req(1'b1);
        repeat (8) @(negedge clk);
        check_b("mid_stalled_write", bus.mgmt_write, 1'b1);
        check("mid_stalled_addr", 32'(bus.mgmt_address), 32'd4);
        pulse_req(1'b0);
        #2 rst = 1'b1;
        #1;
        check_b("mid_rst_write", bus.mgmt_write, 1'b0);
        check("mid_rst_addr", 32'(bus.mgmt_address), 32'h0);
        check("mid_rst_wdata", bus.mgmt_writedata, 32'h0);
        check_b("mid_rst_core_rst", core_rst, 1'b1);
        check_b("mid_rst_busy", busy, 1'b1);
        check_b("mid_rst_cur_sel", cur_sel, 1'b0);
        stall_until = stall_used;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (core_rst && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_release_cycles", n, LS);
        repeat (30) @(negedge clk);
        check("mid_pending_dropped", log_n - base, 2);
        check_b("mid_idle", busy, 1'b0);

`ifdef PLL_CFG_READBACK_EN
        // Readback mismatch on idx1 aborts before the start write
        corrupt = 1'b1;
        base = log_n;
        pulse_req(1'b1);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_b("rb_err", err, 1'b1);
        check("rb_writes", log_n - base, 2);
        check_b("rb_core_rst", core_rst, 1'b1);
        check_b("rb_busy", busy, 1'b0);
        corrupt = 1'b0;
`else
        check("no_reads", rd_seen, 0);
`endif
        check("gap_viol", gap_viol, 0);
        check("hold_viol_final", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
